// File: rtl/cache_req_master.sv
// Request initiator for cache_top: queues commands, issues one re/we pulse each, waits for done or timeout, returns ordered responses.
// Optional statistics counters are built only when CACHE_REQ_MASTER_STATS_EN is defined.
module cache_req_master #(
    parameter int WIDTH      = 8,
    parameter int RAM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_we,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_timeout,
    output logic             cache_we,
    output logic             cache_re,
    output logic [AW-1:0]    cache_addr,
    output logic [WIDTH-1:0] cache_data_in,
    input  logic             cache_done,
    input  logic [WIDTH-1:0] cache_data_out,
    output logic             busy,
    output logic [15:0]      stat_rd,
    output logic [15:0]      stat_wr,
    output logic [15:0]      stat_to,
    output logic [7:0]       stat_lat_max,
    output logic [1:0]       dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + AW + WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             init_q;
    logic             push, pop, full, empty;
    logic             txn_we_q, txn_we_d;
    logic [AW-1:0]    txn_addr_q, txn_addr_d;
    logic [WIDTH-1:0] txn_wdata_q, txn_wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             timeout_q, timeout_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    // init_q keeps cmd_ready low while reset is asserted
    assign cmd_ready = init_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            init_q      <= 1'b0;
            txn_we_q    <= 1'b0;
            txn_addr_q  <= '0;
            txn_wdata_q <= '0;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            init_q      <= 1'b1;
            txn_we_q    <= txn_we_d;
            txn_addr_q  <= txn_addr_d;
            txn_wdata_q <= txn_wdata_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cache_done || (wait_cnt_q == TO_CNT)) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction registers: loaded on pop, counter runs from 1 in the first WAIT cycle
    always_comb begin
        txn_we_d    = txn_we_q;
        txn_addr_d  = txn_addr_q;
        txn_wdata_d = txn_wdata_q;
        rdata_d     = rdata_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {txn_we_d, txn_addr_d, txn_wdata_d} = fifo_mem[rd_ptr_q];
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            S_ISSUE: wait_cnt_d = TW'(1);
            S_WAIT: begin
                if (cache_done)                rdata_d    = txn_we_q ? '0 : cache_data_out;
                else if (wait_cnt_q == TO_CNT) timeout_d  = 1'b1;
                else                           wait_cnt_d = wait_cnt_q + TW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        cache_we      = 1'b0;
        cache_re      = 1'b0;
        cache_addr    = '0;
        cache_data_in = '0;
        rsp_valid     = 1'b0;
        rsp_we        = 1'b0;
        rsp_rdata     = '0;
        rsp_timeout   = 1'b0;
        case (state_q)
            S_ISSUE: begin
                cache_we      = txn_we_q;
                cache_re      = !txn_we_q;
                cache_addr    = txn_addr_q;
                cache_data_in = txn_wdata_q;
            end
            S_WAIT: begin
                cache_addr    = txn_addr_q;
                cache_data_in = txn_wdata_q;
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_we      = txn_we_q;
                rsp_rdata   = rdata_q;
                rsp_timeout = timeout_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_REQ_MASTER_STATS_EN
    logic [15:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d, stat_to_q, stat_to_d;
    logic [7:0]  lat_max_q, lat_max_d, lat_sat;
    logic        done_ev, to_ev;

    assign done_ev = (state_q == S_WAIT) && cache_done;
    assign to_ev   = (state_q == S_WAIT) && !cache_done && (wait_cnt_q == TO_CNT);

    always_comb begin
        lat_sat   = (32'(wait_cnt_q) > 32'd255) ? 8'hFF : 8'(wait_cnt_q);
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        stat_to_d = stat_to_q;
        lat_max_d = lat_max_q;
        if (done_ev && !txn_we_q && (stat_rd_q != 16'hFFFF)) stat_rd_d = stat_rd_q + 16'd1;
        if (done_ev && txn_we_q && (stat_wr_q != 16'hFFFF))  stat_wr_d = stat_wr_q + 16'd1;
        if (to_ev && (stat_to_q != 16'hFFFF))                stat_to_d = stat_to_q + 16'd1;
        if (done_ev && (lat_sat > lat_max_q))                lat_max_d = lat_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
            stat_to_q <= '0;
            lat_max_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
            stat_to_q <= stat_to_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign stat_rd      = stat_rd_q;
    assign stat_wr      = stat_wr_q;
    assign stat_to      = stat_to_q;
    assign stat_lat_max = lat_max_q;
`else
    assign stat_rd      = '0;
    assign stat_wr      = '0;
    assign stat_to      = '0;
    assign stat_lat_max = '0;
`endif

endmodule

// File: tb/tb_cache_req_master.sv
// Directed bench for cache_req_master: reset, single write/read, queue-full burst, timeout, statistics.
module tb_cache_req_master;
    localparam int WIDTH   = 8;
    localparam int AW      = 8;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [WIDTH-1:0] cmd_wdata = '0;
    logic             rsp_valid, rsp_ready = 1'b0, rsp_we, rsp_timeout;
    logic [WIDTH-1:0] rsp_rdata;
    logic             cache_we, cache_re, cache_done = 1'b0;
    logic [AW-1:0]    cache_addr;
    logic [WIDTH-1:0] cache_data_in, cache_data_out = '0;
    logic             busy;
    logic [15:0]      stat_rd, stat_wr, stat_to;
    logic [7:0]       stat_lat_max;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH-1:0] model [256];

    logic             b_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0]    b_addr [5] = '{8'h40, 8'h12, 8'h41, 8'h40, 8'h41};
    logic [WIDTH-1:0] b_wd   [5] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00};
    logic [WIDTH-1:0] b_exp  [5] = '{8'h00, 8'hAB, 8'h00, 8'h11, 8'h22};

    always #5 clk = ~clk;

    cache_req_master #(.WIDTH(WIDTH), .RAM_DEPTH(256), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .cache_we(cache_we), .cache_re(cache_re), .cache_addr(cache_addr),
        .cache_data_in(cache_data_in), .cache_done(cache_done),
        .cache_data_out(cache_data_out), .busy(busy),
        .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_to(stat_to),
        .stat_lat_max(stat_lat_max), .dbg_state(dbg_state)
    );

    // Cache storage model: captures the write presented in the ISSUE cycle
    always @(posedge clk) begin
        if (cache_we) model[cache_addr] <= cache_data_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] wd, input int lat,
                          input logic [WIDTH-1:0] exp_rd, input logic exp_to);
        int k;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
        check_eq({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        step();
        // done raised during ISSUE must be ignored
        cache_done = (lat != 1);
        check_eq({tag, "_issue"}, 32'({cache_we, cache_re}), we ? 32'd2 : 32'd1);
        check_eq({tag, "_addr"}, 32'(cache_addr), 32'(addr));
        if (we) check_eq({tag, "_din"}, 32'(cache_data_in), 32'(wd));
        step();
        cache_done = 1'b0;
        check_eq({tag, "_pulse"}, 32'({cache_we, cache_re}), 32'd0);
        check_eq({tag, "_addr_hold"}, 32'(cache_addr), 32'(addr));
        if (lat > 0) begin
            for (int n = 1; n < lat; n++) step();
            cache_done = 1'b1;
            cache_data_out = model[cache_addr];
            step();
            cache_done = 1'b0;
            cache_data_out = '0;
        end else begin
            k = 0;
            while (!rsp_valid && k < TIMEOUT + 8) begin
                step();
                k++;
            end
            check_eq({tag, "_to_cycles"}, 32'(k), 32'(TIMEOUT));
        end
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_rsp_we"}, 32'(rsp_we), 32'(we));
        check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        check_eq({tag, "_rsp_to"}, 32'(rsp_timeout), 32'(exp_to));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH:0] e;
        int w;
        for (int i = 0; i < 256; i++) model[i] = '0;

        // Power-on reset
        #2;
        check_eq("por_ready", 32'(cmd_ready), 32'd0);
        check_eq("por_busy", 32'(busy), 32'd0);
        check_eq("por_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check_eq("rel_ready", 32'(cmd_ready), 32'd1);
        check_eq("rel_stat", 32'({stat_rd, stat_wr, stat_to[7:0]}), 32'd0);

        // Reset mid-WAIT drops the command
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h34;
        step();
        cmd_valid = 1'b0; cmd_addr = '0;
        step();
        step();
        check_eq("rst_pre_addr", 32'(cache_addr), 32'h34);
        rst_n = 1'b0;
        #1;
        check_eq("rst_addr", 32'(cache_addr), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("rst_after_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_after_busy", 32'(busy), 32'd0);
        check_eq("rst_after_ready", 32'(cmd_ready), 32'd1);

        do_txn("wr12", 1'b1, 8'h12, 8'hAB, 2, 8'h00, 1'b0);
        do_txn("rd12", 1'b0, 8'h12, 8'h00, 3, 8'hAB, 1'b0);
        do_txn("to34", 1'b0, 8'h34, 8'h00, 0, 8'h00, 1'b1);
        do_txn("rd12b", 1'b0, 8'h12, 8'h00, 1, 8'hAB, 1'b0);

`ifdef CACHE_REQ_MASTER_STATS_EN
        check_eq("stat_rd", 32'(stat_rd), 32'd2);
        check_eq("stat_wr", 32'(stat_wr), 32'd1);
        check_eq("stat_to", 32'(stat_to), 32'd1);
        check_eq("stat_lat", 32'(stat_lat_max), 32'd3);
`else
        check_eq("stat_rd", 32'(stat_rd), 32'd0);
        check_eq("stat_wr", 32'(stat_wr), 32'd0);
        check_eq("stat_to", 32'(stat_to), 32'd0);
        check_eq("stat_lat", 32'(stat_lat_max), 32'd0);
`endif

        // Burst of five: four queue entries plus one already popped
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_we = b_we[i]; cmd_addr = b_addr[i]; cmd_wdata = b_wd[i];
            check_eq($sformatf("b%0d_rdy", i), 32'(cmd_ready), 32'd1);
            exp_q.push_back({b_we[i], b_exp[i]});
            step();
        end
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        check_eq("b_full", 32'(cmd_ready), 32'd0);
        check_eq("b_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                w = 0;
                while (!(cache_re || cache_we) && w < 10) begin
                    step();
                    w++;
                end
                check_eq($sformatf("b%0d_issue", i), 32'({cache_we, cache_re}), b_we[i] ? 32'd2 : 32'd1);
                step();
            end
            cache_done = 1'b1;
            cache_data_out = model[cache_addr];
            step();
            cache_done = 1'b0;
            cache_data_out = '0;
            e = exp_q.pop_front();
            check_eq($sformatf("b%0d_rsp", i), 32'({rsp_valid, rsp_timeout, rsp_we, rsp_rdata}),
                     32'({1'b1, 1'b0, e}));
            for (int j = 0; j < 3; j++) begin
                step();
                check_eq($sformatf("b%0d_hold%0d", i, j), 32'({rsp_valid, rsp_we, rsp_rdata}),
                         32'({1'b1, e}));
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        check_eq("b_idle_busy", 32'(busy), 32'd0);
        check_eq("b_idle_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
